// File: rtl/dwpe_post.sv
// dwpe_post: captures dwpe lane results on each rising edge of result_valid[0],
// then adds bias, rounds, shifts, applies ReLU and saturates each lane.
// Finished vectors go into a 2-entry valid/ready output queue.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   result[POX], result_valid   signed lane results and per-lane valid levels
//   bias, shift                 shared bias and right-shift amount, sampled at capture
//   out_data[POX], out_valid    head of the output queue
//   out_ready                   consumer accept
//   overflow, lane_err          sticky error flags, cleared only by rst
//   busy                        any stage or queue entry occupied
module dwpe_post #(
   parameter int DW  = 32,
   parameter int POX = 6,
   parameter int ODW = 8,
   parameter int SW  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [DW-1:0]  result [POX],
   input  logic [POX-1:0]        result_valid,
   input  logic signed [DW-1:0]  bias,
   input  logic [SW-1:0]         shift,
   output logic [ODW-1:0]        out_data [POX],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow,
   output logic                  lane_err,
   output logic                  busy
);

   // Round-half-up arithmetic shift at DW+2 bits, then ReLU and clamp.
   function automatic logic [ODW-1:0] post_lane(
      input logic signed [DW:0] s,
      input logic [SW-1:0]      sh
   );
      logic signed [DW+1:0] rnd;
      logic signed [DW+1:0] r;
      logic signed [DW+1:0] y;
      rnd = '0;
      if (sh != '0) rnd = (DW+2)'(1) << (sh - SW'(1));
      r = {s[DW], s} + rnd;
      y = r >>> sh;
      if (y[DW+1]) return '0;
      if (|y[DW:ODW]) return '1;
      return y[ODW-1:0];
   endfunction

   logic                  rv_q, rv_d;
   logic                  v0_q, v0_d;
   logic signed [DW-1:0]  res0_q [POX];
   logic signed [DW-1:0]  res0_d [POX];
   logic signed [DW-1:0]  bias0_q, bias0_d;
   logic [SW-1:0]         sh0_q, sh0_d;
   logic                  v1_q, v1_d;
   logic signed [DW:0]    s1_q [POX];
   logic signed [DW:0]    s1_d [POX];
   logic [SW-1:0]         sh1_q, sh1_d;
   logic [ODW-1:0]        q0_q [POX];
   logic [ODW-1:0]        q0_d [POX];
   logic [ODW-1:0]        q1_q [POX];
   logic [ODW-1:0]        q1_d [POX];
   logic [1:0]            cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  lerr_q, lerr_d;

   logic                  cap;
   logic                  push;
   logic                  pop;
   logic [ODW-1:0]        s2_vec [POX];

   always_comb begin
      // S0: one capture per rising edge of lane 0 valid
      cap      = result_valid[0] & ~rv_q;
      rv_d     = result_valid[0];
      v0_d     = cap;
      res0_d   = res0_q;
      bias0_d  = bias0_q;
      sh0_d    = sh0_q;
      lerr_d   = lerr_q;
      if (cap) begin
         res0_d  = result;
         bias0_d = bias;
         sh0_d   = shift;
         if (result_valid != {POX{result_valid[0]}}) lerr_d = 1'b1;
      end

      // S1: bias add, one extra bit so the sum never wraps
      v1_d  = v0_q;
      s1_d  = s1_q;
      sh1_d = sh1_q;
      if (v0_q) begin
         for (int i = 0; i < POX; i++)
            s1_d[i] = {res0_q[i][DW-1], res0_q[i]} + {bias0_q[DW-1], bias0_q};
         sh1_d = sh0_q;
      end

      // S2 is combinational from S1 and feeds the queue write directly
      for (int i = 0; i < POX; i++)
         s2_vec[i] = post_lane(s1_q[i], sh1_q);

      // Queue: q0 is always the head entry
      push  = v1_q;
      pop   = (cnt_q != 2'd0) & out_ready;
      q0_d  = q0_q;
      q1_d  = q1_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push & pop) begin
         if (cnt_q == 2'd1) begin
            q0_d = s2_vec;
         end else begin
            q0_d = q1_q;
            q1_d = s2_vec;
         end
      end else if (pop) begin
         q0_d  = q1_q;
         cnt_d = cnt_q - 2'd1;
      end else if (push) begin
         if (cnt_q == 2'd0) begin
            q0_d  = s2_vec;
            cnt_d = 2'd1;
         end else if (cnt_q == 2'd1) begin
            q1_d  = s2_vec;
            cnt_d = 2'd2;
         end else begin
            // dwpe cannot be stalled: drop and flag
            ovf_d = 1'b1;
         end
      end

      // Outputs read zero in any cycle with rst asserted
      out_valid = ~rst & (cnt_q != 2'd0);
      overflow  = ~rst & ovf_q;
      lane_err  = ~rst & lerr_q;
      busy      = ~rst & (v0_q | v1_q | (cnt_q != 2'd0));
      for (int i = 0; i < POX; i++)
         out_data[i] = rst ? '0 : q0_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rv_q    <= 1'b0;
         v0_q    <= 1'b0;
         res0_q  <= '{default: '0};
         bias0_q <= '0;
         sh0_q   <= '0;
         v1_q    <= 1'b0;
         s1_q    <= '{default: '0};
         sh1_q   <= '0;
         q0_q    <= '{default: '0};
         q1_q    <= '{default: '0};
         cnt_q   <= 2'd0;
         ovf_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         rv_q    <= rv_d;
         v0_q    <= v0_d;
         res0_q  <= res0_d;
         bias0_q <= bias0_d;
         sh0_q   <= sh0_d;
         v1_q    <= v1_d;
         s1_q    <= s1_d;
         sh1_q   <= sh1_d;
         q0_q    <= q0_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         lerr_q  <= lerr_d;
      end
   end

endmodule

// File: tb/tb_dwpe_post.sv
// tb_dwpe_post: table-driven vectors, directed multi-cycle sequences and a
// randomized phase, all checked against a behavioural model of dwpe_post.
module tb_dwpe_post;

   localparam int DW  = 32;
   localparam int POX = 6;
   localparam int ODW = 8;
   localparam int SW  = 5;

   typedef logic [POX*ODW-1:0] pvec_t;
   typedef logic [POX-1:0][DW-1:0] lanes_t;

   typedef struct {
      lanes_t        lanes;
      logic [DW-1:0] b;
      logic [SW-1:0] sh;
      pvec_t         exp;
   } vec_rec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] result [POX];
   logic [POX-1:0]       result_valid;
   logic signed [DW-1:0] bias;
   logic [SW-1:0]        shift;
   logic [ODW-1:0]       out_data [POX];
   logic                 out_valid;
   logic                 out_ready;
   logic                 overflow;
   logic                 lane_err;
   logic                 busy;

   int n_chk  = 0;
   int n_fail = 0;
   int nvalid = 0;

   dwpe_post #(.DW(DW), .POX(POX), .ODW(ODW), .SW(SW)) dut (
      .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
      .bias(bias), .shift(shift), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .overflow(overflow), .lane_err(lane_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   pvec_t m_fifo[$];
   pvec_t m_pipe[$];
   int    m_rem[$];
   logic  m_rv, m_ovf, m_lerr;

   function automatic logic [7:0] ref_lane(longint r, longint b, int sh);
      longint s, d, y;
      s = r + b;
      d = 1;
      repeat (sh) d = d * 2;
      if (sh > 0) s = s + d / 2;
      if (s >= 0) y = s / d;
      else y = -((-s + d - 1) / d);
      if (y < 0) return 8'd0;
      if (y > 255) return 8'd255;
      return 8'(y);
   endfunction

   function automatic pvec_t ref_vec();
      pvec_t v;
      for (int i = 0; i < POX; i++)
         v[i*8 +: 8] = ref_lane(longint'(result[i]), longint'(bias), int'(shift));
      return v;
   endfunction

   function automatic pvec_t dut_vec();
      pvec_t v;
      for (int i = 0; i < POX; i++) v[i*8 +: 8] = out_data[i];
      return v;
   endfunction

   function automatic lanes_t mk6(int a0, int a1, int a2, int a3, int a4, int a5);
      lanes_t l;
      l[0] = a0; l[1] = a1; l[2] = a2; l[3] = a3; l[4] = a4; l[5] = a5;
      return l;
   endfunction

   function automatic pvec_t mke(logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                                 logic [7:0] a3, logic [7:0] a4, logic [7:0] a5);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      pvec_t pv;
      logic  push;
      if (rst) begin
         m_fifo.delete(); m_pipe.delete(); m_rem.delete();
         m_rv = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0;
         return;
      end
      push = 1'b0;
      pv   = '0;
      for (int i = 0; i < m_rem.size(); i++) m_rem[i] = m_rem[i] - 1;
      if (m_rem.size() > 0 && m_rem[0] == 0) begin
         pv = m_pipe.pop_front();
         void'(m_rem.pop_front());
         push = 1'b1;
      end
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() >= 2) m_ovf = 1'b1;
         else m_fifo.push_back(pv);
      end
      if (result_valid[0] && !m_rv) begin
         m_pipe.push_back(ref_vec());
         m_rem.push_back(2);
         if (result_valid != {POX{result_valid[0]}}) m_lerr = 1'b1;
      end
      m_rv = result_valid[0];
   endtask

   task automatic compare();
      if (out_valid === 1'b1) nvalid++;
      if (rst) begin
         check("rst_out_valid", 64'(out_valid), 0);
         check("rst_out_data", 64'(dut_vec()), 0);
         check("rst_overflow", 64'(overflow), 0);
         check("rst_lane_err", 64'(lane_err), 0);
         check("rst_busy", 64'(busy), 0);
      end else begin
         check("out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
         check("busy", 64'(busy), 64'((m_fifo.size() > 0) || (m_pipe.size() > 0)));
         check("overflow", 64'(overflow), 64'(m_ovf));
         check("lane_err", 64'(lane_err), 64'(m_lerr));
         if (m_fifo.size() > 0) check("out_data", 64'(dut_vec()), 64'(m_fifo[0]));
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic load(lanes_t l, logic [DW-1:0] b, logic [SW-1:0] sh);
      for (int i = 0; i < POX; i++) result[i] = l[i];
      bias  = b;
      shift = sh;
   endtask

   task automatic load_rand();
      for (int i = 0; i < POX; i++)
         if ($urandom_range(0, 3) == 0) result[i] = $urandom;
         else result[i] = int'($urandom_range(0, 3000)) - 1000;
      if ($urandom_range(0, 3) == 0) bias = $urandom;
      else bias = int'($urandom_range(0, 400)) - 200;
      if ($urandom_range(0, 4) == 0) shift = SW'($urandom_range(0, 31));
      else shift = SW'($urandom_range(0, 4));
   endtask

   // ---------------- stimulus ----------------
   vec_rec_t tbl [7];
   pvec_t    v32;

   initial begin
      tbl[0] = '{lanes: mk6(100, 100, 100, 100, 100, 100), b: 28, sh: 2,
                 exp: mke(32, 32, 32, 32, 32, 32)};
      tbl[1] = '{lanes: mk6(-50, 5000, 6, 7, 0, 255), b: 0, sh: 0,
                 exp: mke(0, 255, 6, 7, 0, 255)};
      tbl[2] = '{lanes: mk6(-50, 5000, 6, 7, 0, 255), b: 0, sh: 1,
                 exp: mke(0, 255, 3, 4, 0, 128)};
      tbl[3] = '{lanes: mk6(-3, -2, -1, 1, 2, 3), b: 0, sh: 1,
                 exp: mke(0, 0, 0, 1, 1, 2)};
      tbl[4] = '{lanes: mk6(1000, 200, 130, 129, 128, 0), b: 32'hFFFFFF80, sh: 2,
                 exp: mke(218, 18, 1, 0, 0, 0)};
      tbl[5] = '{lanes: mk6(32'h7FFFFFFF, 32'h80000000, 511, 512, 256, 1023),
                 b: 32'h7FFFFFFF, sh: 31, exp: mke(2, 0, 1, 1, 1, 1)};
      tbl[6] = '{lanes: mk6(32'h80000000, 0, 300, 256, 255, -1), b: 0, sh: 0,
                 exp: mke(0, 0, 255, 255, 255, 0)};
      v32 = mke(32, 32, 32, 32, 32, 32);

      rst = 1'b1;
      result_valid = '0;
      out_ready = 1'b1;
      load(mk6(0, 0, 0, 0, 0, 0), 0, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // table-driven vectors: latency 3, single-cycle valid with ready high
      for (int k = 0; k < 7; k++) begin
         result_valid = '0;
         load(tbl[k].lanes, tbl[k].b, tbl[k].sh);
         tick();
         result_valid = '1;
         tick();
         result_valid = '0;
         load_rand();
         tick();
         check($sformatf("tbl%0d_early", k), 64'(out_valid), 0);
         tick();
         check($sformatf("tbl%0d_valid", k), 64'(out_valid), 1);
         check($sformatf("tbl%0d_data", k), 64'(dut_vec()), 64'(tbl[k].exp));
         tick();
         check($sformatf("tbl%0d_pulse", k), 64'(out_valid), 0);
      end

      // held valid: one vector per rising edge
      nvalid = 0;
      load(tbl[0].lanes, tbl[0].b, tbl[0].sh);
      result_valid = '1;
      repeat (6) tick();
      check("held_one", 64'(nvalid), 1);
      result_valid = '0;
      tick();
      result_valid = '1;
      repeat (2) tick();
      result_valid = '0;
      repeat (5) tick();
      check("held_two", 64'(nvalid), 2);

      // backpressure: third vector dropped, first two drain in order
      out_ready = 1'b0;
      tick();
      for (int j = 0; j < 3; j++) begin
         load(mk6(10*(j+1), 10*(j+1), 10*(j+1), 10*(j+1), 10*(j+1), 10*(j+1)), 0, 0);
         result_valid = '1;
         tick();
         result_valid = '0;
         tick();
      end
      repeat (4) tick();
      check("bp_overflow", 64'(overflow), 1);
      check("bp_valid", 64'(out_valid), 1);
      check("bp_head1", 64'(dut_vec()), 64'(mke(10, 10, 10, 10, 10, 10)));
      tick();
      check("bp_hold", 64'(dut_vec()), 64'(mke(10, 10, 10, 10, 10, 10)));
      out_ready = 1'b1;
      tick();
      check("bp_head2", 64'(dut_vec()), 64'(mke(20, 20, 20, 20, 20, 20)));
      check("bp_busy_mid", 64'(busy), 1);
      tick();
      check("bp_drained", 64'(out_valid), 0);
      check("bp_busy_low", 64'(busy), 0);
      check("bp_ovf_sticky", 64'(overflow), 1);

      // lane mismatch: vector still produced, lane_err sticky
      load(tbl[0].lanes, tbl[0].b, tbl[0].sh);
      result_valid = 6'b110111;
      tick();
      result_valid = '0;
      tick();
      tick();
      check("lm_valid", 64'(out_valid), 1);
      check("lm_data", 64'(dut_vec()), 64'(v32));
      check("lm_err", 64'(lane_err), 1);
      repeat (5) tick();
      check("lm_sticky", 64'(lane_err), 1);

      // reset one cycle after a capture discards the vector
      nvalid = 0;
      result_valid = '1;
      tick();
      result_valid = '0;
      rst = 1'b1;
      tick();
      check("rmf_valid", 64'(out_valid), 0);
      check("rmf_data", 64'(dut_vec()), 0);
      rst = 1'b0;
      repeat (4) tick();
      check("rmf_none", 64'(nvalid), 0);
      check("rmf_ovf_clr", 64'(overflow), 0);
      check("rmf_lerr_clr", 64'(lane_err), 0);
      result_valid = '1;
      tick();
      result_valid = '0;
      tick();
      tick();
      check("rmf_after_valid", 64'(out_valid), 1);
      check("rmf_after_data", 64'(dut_vec()), 64'(v32));
      tick();

      // valid already high when reset releases counts as a rising edge
      rst = 1'b1;
      result_valid = '1;
      tick();
      rst = 1'b0;
      tick();
      result_valid = '0;
      tick();
      tick();
      check("rhi_valid", 64'(out_valid), 1);
      check("rhi_data", 64'(dut_vec()), 64'(v32));
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         load_rand();
         result_valid = {POX{$urandom_range(0, 1) == 1}};
         if ($urandom_range(0, 19) == 0) result_valid[POX-1:1] = (POX-1)'($urandom);
         tick();
      end
      rst = 1'b0;
      result_valid = '0;
      out_ready = 1'b1;
      repeat (6) tick();
      check("final_idle", 64'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dwpe_post.md
# dwpe_post

Post-processing stage directly downstream of `dwpe`. It captures the POX parallel depthwise MAC results on each rising edge of the PE's result-valid level, then applies four steps per lane: bias add, rounded arithmetic right shift, ReLU and unsigned saturation to ODW bits. Finished vectors are buffered in a 2-entry output queue with valid/ready handshake toward the pointwise stage / output buffer. The queue absorbs backpressure; `dwpe` itself cannot be stalled, so overflow is flagged rather than back-propagated.

## Interface
- `DW`, 32, width of each signed `dwpe` result lane and of `bias`
- `POX`, 6, number of parallel lanes
- `ODW`, 8, unsigned output lane width
- `SW`, 5, width of the `shift` control

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `result[POX]`  in  DW each  signed lane results from `dwpe`
- `result_valid[POX]`  in  1 each  per-lane valid level from `dwpe`; may stay high several cycles
- `bias`  in  DW  signed bias, shared by all lanes; sampled at capture
- `shift`  in  SW  right-shift amount, 0..DW-1; sampled at capture
- `out_data[POX]`  out  ODW each  post-processed lanes
- `out_valid`  out  1  head of queue valid
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `overflow`  out  1  sticky: a vector was dropped because the queue was full
- `lane_err`  out  1  sticky: lanes of `result_valid` disagreed at a capture edge
- `busy`  out  1  any pipeline stage or queue entry occupied

## Operation
- **Capture (S0)**
  - Register `rv_d <= result_valid[0]` every cycle.
  - Capture event when `result_valid[0] && !rv_d`. Exactly one capture per rising edge, regardless of how long the level is held.
  - On capture, latch all `result` lanes, `bias` and `shift`. Set `lane_err` if any `result_valid[i] != result_valid[0]`.
- **S1, bias add**
  - `s1[i] = sext(result[i]) + sext(bias)`, held at DW+1 bits with no wrap.
- **S2, round, shift, clamp**
  - `r = s1[i] + (shift>0 ? 1<<(shift-1) : 0)`, computed at DW+2 bits.
  - `y = r >>> shift` (arithmetic, round-half-up).
  - Clamp: `y<0` → 0; `y > 2^ODW-1` → `2^ODW-1`; otherwise `y[ODW-1:0]`.
- **Queue**
  - 2-entry FIFO of POX×ODW vectors.
  - The S2 result is written when the S2 valid bit is set.
  - If the queue is full and no pop occurs in the same cycle, the vector is dropped and `overflow` is set.
  - A push and a pop in the same cycle on a full queue is legal: no drop.
  - `out_data` always reflects the head entry; its value is don't-care when `out_valid=0`.
- **Stages**
  - S0/S1/S2 never stall; each carries a valid bit.
- **Sticky flags**
  - `overflow` and `lane_err` clear only on `rst`.
- **Busy**
  - `busy = v0|v1|v2|(count!=0)`.

## Timing
- **Reset**
  - On a cycle with `rst=1`: `out_valid=0`, `out_data=0`, `overflow=0`, `lane_err=0`, `busy=0`.
  - All stage valid bits are cleared, queue count goes to 0 and `rv_d` goes to 0.
  - Reset mid-operation discards all in-flight and queued vectors.
  - A `result_valid[0]` that is already high when reset releases counts as a rising edge on the first cycle after reset.
- **Latency**
  - Capture edge sampled in cycle 0; S1 registers end of cycle 1; queue written end of cycle 2.
  - `out_valid=1` in cycle 3 when the queue was empty.
- **Throughput**
  - One capture per 2 cycles minimum, since a rising edge needs one low cycle.
  - Sustained rate is limited by the consumer.
- **Handshake**
  - `out_valid` stays high and `out_data` stays stable until accepted.
  - A pop in cycle t presents the next entry in cycle t+1.
- **Order**
  - Output order equals capture order; dropped vectors leave no gap marker.

## Test plan
- **Basic:** all lanes `result=100`, `bias=28`, `shift=2`, `out_ready=1` → `out_data=32` on all lanes, `out_valid` for exactly 1 cycle, 3 cycles after the capture edge.
- **ReLU/saturate/round:** lanes {-50, 5000, 6, 7, 0, 255}, `bias=0`, `shift=0` then `shift=1` → {0,255,6,7,0,255} then {0,255,3,4,0,128}.
- **Held valid:** `result_valid` high for 6 cycles → exactly one output vector; dropping low 1 cycle then high again → second vector.
- **Backpressure:** `out_ready=0`, three capture events 2 cycles apart → first two held in order, third dropped, `overflow=1`. Then `out_ready=1` → two vectors drain, `busy` falls 0 after the last pop.
- **Lane mismatch:** `result_valid[3]=0` while the others rise → vector still produced, `lane_err=1` and staying set until `rst`.
- **Reset mid-flight:** assert `rst` one cycle after a capture → no output appears, all outputs 0. Next capture after release behaves as in the basic case.
